// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that shares four byte-lane 32x8 RAM macros between two word requesters.
// Optional per-lane byte write enables are compiled in with RAM_ARB_BYTE_WE_EN.
module ram_rr_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              REQ1,
    input  logic              REQ2,
    input  logic              WE1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [ADDR_W-1:0] ADDR2,
    input  logic [DATA_W-1:0] WDATA1,
    input  logic [DATA_W-1:0] WDATA2,
    input  logic [3:0]        BE1,
    input  logic [3:0]        BE2,
    output logic              ACK1,
    output logic              ACK2,
    output logic [DATA_W-1:0] RDATA1,
    output logic [DATA_W-1:0] RDATA2,
    output logic              BUSY,
    output logic              RAM_CSb0,
    output logic              RAM_CSb1,
    output logic              RAM_CSb2,
    output logic              RAM_CSb3,
    output logic              RAM_WEb0,
    output logic              RAM_WEb1,
    output logic              RAM_WEb2,
    output logic              RAM_WEb3,
    output logic [ADDR_W-3:0] RAM_ADDR0,
    output logic [ADDR_W-3:0] RAM_ADDR1,
    output logic [ADDR_W-3:0] RAM_ADDR2,
    output logic [ADDR_W-3:0] RAM_ADDR3,
    output logic [7:0]        RAM_DATA_IN0,
    output logic [7:0]        RAM_DATA_IN1,
    output logic [7:0]        RAM_DATA_IN2,
    output logic [7:0]        RAM_DATA_IN3,
    input  logic [7:0]        RAM_DATA_OUT0,
    input  logic [7:0]        RAM_DATA_OUT1,
    input  logic [7:0]        RAM_DATA_OUT2,
    input  logic [7:0]        RAM_DATA_OUT3
);
    localparam int unsigned WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_next;

    // gnt / last_gnt: 0 selects requester 1, 1 selects requester 2
    logic              gnt;
    logic              last_gnt;
    logic              pend1, pend2;
    logic              grant_valid;
    logic              grant_sel;
    logic              lat_we;
    logic [WA_W-1:0]   lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_be;
    logic [3:0]        lane_csb;
    logic [3:0]        lane_web;
    logic [WA_W-1:0]   lane_addr;
    logic [DATA_W-1:0] lane_din;
    logic [DATA_W-1:0] rd_word;
    logic              unused_bits;

    assign rd_word = {RAM_DATA_OUT3, RAM_DATA_OUT2, RAM_DATA_OUT1, RAM_DATA_OUT0};

    always_comb begin
        // a requester is not re-granted during its own ACK cycle
        pend1       = REQ1 & ~ACK1;
        pend2       = REQ2 & ~ACK2;
        grant_valid = pend1 | pend2;
        grant_sel   = pend2;
        if (pend1 && pend2) begin
            grant_sel = ~last_gnt;
        end
        state_next = IDLE;
        case (state)
            IDLE:    state_next = grant_valid ? ISSUE : IDLE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            ACK1      <= 1'b0;
            ACK2      <= 1'b0;
            RDATA1    <= '0;
            RDATA2    <= '0;
        end else begin
            state <= state_next;
            ACK1  <= 1'b0;
            ACK2  <= 1'b0;
            if (state == IDLE && grant_valid) begin
                gnt       <= grant_sel;
                last_gnt  <= grant_sel;
                lat_we    <= grant_sel ? WE2 : WE1;
                lat_addr  <= grant_sel ? ADDR2[ADDR_W-1:2] : ADDR1[ADDR_W-1:2];
                lat_wdata <= grant_sel ? WDATA2 : WDATA1;
                lat_be    <= grant_sel ? BE2 : BE1;
            end
            if (state == CAPTURE) begin
                if (gnt) begin
                    ACK2 <= 1'b1;
                    if (!lat_we) RDATA2 <= rd_word;
                end else begin
                    ACK1 <= 1'b1;
                    if (!lat_we) RDATA1 <= rd_word;
                end
            end
        end
    end

    always_comb begin
        lane_csb  = 4'hF;
        lane_web  = 4'hF;
        lane_addr = '0;
        lane_din  = '0;
        if (state == ISSUE) begin
            lane_csb  = 4'h0;
            lane_addr = lat_addr;
            lane_din  = lat_wdata;
`ifdef RAM_ARB_BYTE_WE_EN
            lane_web  = lat_we ? ~lat_be : 4'hF;
`else
            lane_web  = {4{~lat_we}};
`endif
        end
    end

`ifdef RAM_ARB_BYTE_WE_EN
    assign unused_bits = ^{ADDR1[1:0], ADDR2[1:0]};
`else
    assign unused_bits = ^{ADDR1[1:0], ADDR2[1:0], lat_be};
`endif

    assign BUSY         = (state != IDLE);
    assign RAM_CSb0     = lane_csb[0];
    assign RAM_CSb1     = lane_csb[1];
    assign RAM_CSb2     = lane_csb[2];
    assign RAM_CSb3     = lane_csb[3];
    assign RAM_WEb0     = lane_web[0];
    assign RAM_WEb1     = lane_web[1];
    assign RAM_WEb2     = lane_web[2];
    assign RAM_WEb3     = lane_web[3];
    assign RAM_ADDR0    = lane_addr;
    assign RAM_ADDR1    = lane_addr;
    assign RAM_ADDR2    = lane_addr;
    assign RAM_ADDR3    = lane_addr;
    assign RAM_DATA_IN0 = lane_din[7:0];
    assign RAM_DATA_IN1 = lane_din[15:8];
    assign RAM_DATA_IN2 = lane_din[23:16];
    assign RAM_DATA_IN3 = lane_din[31:24];

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: byte-lane RAM model plus a word-level reference memory.
// Honours RAM_ARB_BYTE_WE_EN when computing expected write results.
module tb_ram_rr_arbiter;
    logic        CLK = 1'b0;
    logic        RSTb;
    logic        REQ1, REQ2, WE1, WE2;
    logic [6:0]  ADDR1, ADDR2;
    logic [31:0] WDATA1, WDATA2;
    logic [3:0]  BE1, BE2;
    logic        ACK1, ACK2, BUSY;
    logic [31:0] RDATA1, RDATA2;
    logic        RAM_CSb0, RAM_CSb1, RAM_CSb2, RAM_CSb3;
    logic        RAM_WEb0, RAM_WEb1, RAM_WEb2, RAM_WEb3;
    logic [4:0]  RAM_ADDR0, RAM_ADDR1, RAM_ADDR2, RAM_ADDR3;
    logic [7:0]  RAM_DATA_IN0, RAM_DATA_IN1, RAM_DATA_IN2, RAM_DATA_IN3;
    logic [7:0]  RAM_DATA_OUT0, RAM_DATA_OUT1, RAM_DATA_OUT2, RAM_DATA_OUT3;

`ifdef RAM_ARB_BYTE_WE_EN
    localparam bit BYTE_WE = 1'b1;
`else
    localparam bit BYTE_WE = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    ram_rr_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .REQ1(REQ1), .REQ2(REQ2), .WE1(WE1), .WE2(WE2),
        .ADDR1(ADDR1), .ADDR2(ADDR2), .WDATA1(WDATA1), .WDATA2(WDATA2),
        .BE1(BE1), .BE2(BE2), .ACK1(ACK1), .ACK2(ACK2),
        .RDATA1(RDATA1), .RDATA2(RDATA2), .BUSY(BUSY),
        .RAM_CSb0(RAM_CSb0), .RAM_CSb1(RAM_CSb1), .RAM_CSb2(RAM_CSb2), .RAM_CSb3(RAM_CSb3),
        .RAM_WEb0(RAM_WEb0), .RAM_WEb1(RAM_WEb1), .RAM_WEb2(RAM_WEb2), .RAM_WEb3(RAM_WEb3),
        .RAM_ADDR0(RAM_ADDR0), .RAM_ADDR1(RAM_ADDR1), .RAM_ADDR2(RAM_ADDR2), .RAM_ADDR3(RAM_ADDR3),
        .RAM_DATA_IN0(RAM_DATA_IN0), .RAM_DATA_IN1(RAM_DATA_IN1),
        .RAM_DATA_IN2(RAM_DATA_IN2), .RAM_DATA_IN3(RAM_DATA_IN3),
        .RAM_DATA_OUT0(RAM_DATA_OUT0), .RAM_DATA_OUT1(RAM_DATA_OUT1),
        .RAM_DATA_OUT2(RAM_DATA_OUT2), .RAM_DATA_OUT3(RAM_DATA_OUT3)
    );

    always #5 CLK = ~CLK;

    // byte-lane RAM macros: synchronous write, registered read
    logic [7:0] lane_mem [4][32] = '{default: '0};
    logic [7:0] dout [4];
    logic [3:0] csb, web;
    logic [4:0] ra [4];
    logic [7:0] din [4];
    assign csb = {RAM_CSb3, RAM_CSb2, RAM_CSb1, RAM_CSb0};
    assign web = {RAM_WEb3, RAM_WEb2, RAM_WEb1, RAM_WEb0};
    assign ra[0] = RAM_ADDR0;  assign ra[1] = RAM_ADDR1;
    assign ra[2] = RAM_ADDR2;  assign ra[3] = RAM_ADDR3;
    assign din[0] = RAM_DATA_IN0;  assign din[1] = RAM_DATA_IN1;
    assign din[2] = RAM_DATA_IN2;  assign din[3] = RAM_DATA_IN3;
    assign RAM_DATA_OUT0 = dout[0];  assign RAM_DATA_OUT1 = dout[1];
    assign RAM_DATA_OUT2 = dout[2];  assign RAM_DATA_OUT3 = dout[3];

    always @(posedge CLK) begin
        for (int n = 0; n < 4; n++) begin
            if (!csb[n]) begin
                if (!web[n]) lane_mem[n][ra[n]] <= din[n];
                dout[n] <= lane_mem[n][ra[n]];
            end
        end
    end

    // word-level reference model
    logic [31:0] ref_mem [32];
    logic [31:0] exp_rd [1:2];
    int          last_r;
    logic        cur_we [1:2];
    logic [6:0]  cur_a  [1:2];
    logic [31:0] cur_wd [1:2];
    logic [3:0]  cur_be [1:2];
    logic [3:0]  snap_csb, snap_web;
    logic [19:0] snap_addr;
    logic [31:0] snap_din;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] res = old;
        for (int i = 0; i < 4; i++) if (be[i] || !BYTE_WE) res[8*i +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    function automatic void model_complete(input int r, input logic we, input logic [6:0] a,
                                           input logic [31:0] wd, input logic [3:0] be);
        if (we) ref_mem[a[6:2]] = merge(ref_mem[a[6:2]], wd, be);
        else    exp_rd[r] = ref_mem[a[6:2]];
    endfunction

    task automatic drive(input int r, input logic req, input logic we, input logic [6:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (r == 1) begin REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = wd; BE1 = be; end
        else        begin REQ2 = req; WE2 = we; ADDR2 = a; WDATA2 = wd; BE2 = be; end
    endtask

    task automatic new_op(input int r);
        cur_we[r] = 1'($urandom_range(0, 1));
        cur_a[r]  = 7'($urandom);
        cur_wd[r] = $urandom;
        cur_be[r] = 4'($urandom);
        drive(r, 1'b1, cur_we[r], cur_a[r], cur_wd[r], cur_be[r]);
    endtask

    task automatic apply_reset();
        RSTb = 1'b0;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge CLK);
        #1 RSTb = 1'b1;
        exp_rd[1] = '0;
        exp_rd[2] = '0;
        last_r    = 2;
    endtask

    // one isolated transaction; lat = cycles from request to ACK, -1 on timeout
    task automatic do_txn(input int r, input logic we, input logic [6:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output int lat, output logic [31:0] rd);
        drive(r, 1'b1, we, a, wd, be);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 1) begin
                snap_csb  = csb;
                snap_web  = web;
                snap_addr = {RAM_ADDR3, RAM_ADDR2, RAM_ADDR1, RAM_ADDR0};
                snap_din  = {RAM_DATA_IN3, RAM_DATA_IN2, RAM_DATA_IN1, RAM_DATA_IN0};
            end
        end while (!(r == 1 ? ACK1 : ACK2) && lat < 20);
        if (!(r == 1 ? ACK1 : ACK2)) lat = -1;
        else model_complete(r, we, a, wd, be);
        rd = (r == 1) ? RDATA1 : RDATA2;
        drive(r, 1'b0, we, a, wd, be);
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd; bit seen;
        apply_reset();
        total++; if ({ACK1, ACK2, BUSY} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {ACK1, ACK2, BUSY}); end
        total++; if ({RDATA1, RDATA2} !== 64'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", {RDATA1, RDATA2}); end
        total++; if ({csb, web} !== 8'hFF) begin bad++; $display("FAIL rst_ram_ctl: got %h want ff", {csb, web}); end
        total++; if ({RAM_ADDR3, RAM_ADDR2, RAM_ADDR1, RAM_ADDR0, RAM_DATA_IN3, RAM_DATA_IN2, RAM_DATA_IN1, RAM_DATA_IN0} !== 52'h0) begin
            bad++; $display("FAIL rst_ram_bus: got nonzero want 0"); end
        do_txn(1, 1'b1, 7'h00, 32'h1122_3344, 4'hF, lat, rd);
        do_txn(1, 1'b0, 7'h00, 32'h0, 4'hF, lat, rd);
        total++; if (rd !== 32'h1122_3344) begin bad++; $display("FAIL rst_pre_read: got %h want 11223344", rd); end
        drive(1, 1'b1, 1'b1, 7'h04, 32'hCAFE_F00D, 4'hF);
        @(posedge CLK); #1;
        total++; if ({BUSY, csb} !== 5'b1_0000) begin bad++; $display("FAIL rst_in_issue: got %b want 10000", {BUSY, csb}); end
        #2 RSTb = 1'b0;
        #1;
        total++; if ({csb, web, BUSY, ACK1, ACK2} !== 11'b1111_1111_000) begin
            bad++; $display("FAIL rst_async: got %b want 11111111000", {csb, web, BUSY, ACK1, ACK2}); end
        total++; if (RDATA1 !== 32'h0) begin bad++; $display("FAIL rst_async_rdata: got %h want 0", RDATA1); end
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge CLK); #1 RSTb = 1'b1;
        exp_rd[1] = '0; exp_rd[2] = '0; last_r = 2;
        total++; if ({lane_mem[3][1], lane_mem[2][1], lane_mem[1][1], lane_mem[0][1]} !== ref_mem[1]) begin
            bad++; $display("FAIL rst_no_write: got %h want %h", {lane_mem[3][1], lane_mem[2][1], lane_mem[1][1], lane_mem[0][1]}, ref_mem[1]); end
        seen = 1'b0;
        repeat (6) begin @(posedge CLK); #1; if (ACK1 || ACK2 || BUSY) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_dropped: got activity=1 want 0"); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd;
        do_txn(1, 1'b1, 7'h14, 32'hA5A5_1234, 4'hF, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if ({snap_csb, snap_web} !== 8'h00) begin bad++; $display("FAIL wr_issue_ctl: got %h want 00", {snap_csb, snap_web}); end
        total++; if (snap_addr !== {4{5'd5}}) begin bad++; $display("FAIL wr_issue_addr: got %h want %h", snap_addr, {4{5'd5}}); end
        total++; if (snap_din !== 32'hA5A5_1234) begin bad++; $display("FAIL wr_issue_din: got %h want a5a51234", snap_din); end
        do_txn(1, 1'b0, 7'h14, 32'h0, 4'hF, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (snap_web !== 4'hF) begin bad++; $display("FAIL rd_issue_web: got %h want f", snap_web); end
        total++; if (rd !== 32'hA5A5_1234) begin bad++; $display("FAIL rd_data: got %h want a5a51234", rd); end
        total++; if (RDATA2 !== exp_rd[2]) begin bad++; $display("FAIL rd_other: got %h want %h", RDATA2, exp_rd[2]); end
    endtask

    task automatic test_simultaneous();
        int k, cyc, r; bit dbl;
        apply_reset();
        new_op(1); new_op(2);
        k = 0; cyc = 0; dbl = 1'b0;
        while (k < 6 && cyc < 40) begin
            @(posedge CLK); #1; cyc++;
            if (ACK1 && ACK2) dbl = 1'b1;
            else if (ACK1 || ACK2) begin
                r = ACK1 ? 1 : 2;
                total++; if (r !== 3 - last_r) begin bad++; $display("FAIL sim_order%0d: got %0d want %0d", k, r, 3 - last_r); end
                total++; if (cyc !== 3 * (k + 1)) begin bad++; $display("FAIL sim_time%0d: got %0d want %0d", k, cyc, 3 * (k + 1)); end
                last_r = r;
                model_complete(r, cur_we[r], cur_a[r], cur_wd[r], cur_be[r]);
                total++; if ({RDATA1, RDATA2} !== {exp_rd[1], exp_rd[2]}) begin
                    bad++; $display("FAIL sim_data%0d: got %h want %h", k, {RDATA1, RDATA2}, {exp_rd[1], exp_rd[2]}); end
                k++;
                if (k < 6) new_op(r);
                else begin REQ1 = 1'b0; REQ2 = 1'b0; end
            end
        end
        REQ1 = 1'b0; REQ2 = 1'b0;
        total++; if (k !== 6) begin bad++; $display("FAIL sim_count: got %0d want 6", k); end
        total++; if (dbl !== 1'b0) begin bad++; $display("FAIL sim_double: got 1 want 0"); end
        repeat (4) @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        int k, cyc, prev; bit stray;
        new_op(2);
        k = 0; cyc = 0; prev = 0; stray = 1'b0;
        while (k < 5 && cyc < 60) begin
            @(posedge CLK); #1; cyc++;
            if (ACK1) stray = 1'b1;
            if (ACK2) begin
                // a reissue in the ACK cycle is masked for one edge
                total++; if (cyc - prev !== (k == 0 ? 3 : 4)) begin
                    bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, cyc - prev, (k == 0 ? 3 : 4)); end
                prev = cyc;
                model_complete(2, cur_we[2], cur_a[2], cur_wd[2], cur_be[2]);
                total++; if (RDATA2 !== exp_rd[2]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", k, RDATA2, exp_rd[2]); end
                k++;
                if (k < 5) new_op(2); else REQ2 = 1'b0;
            end
        end
        REQ2 = 1'b0;
        total++; if ({k, stray} !== {32'd5, 1'b0}) begin bad++; $display("FAIL b2b_count: got %0d/%b want 5/0", k, stray); end
        repeat (3) @(posedge CLK); #1;
    endtask

    task automatic test_byte_enables();
        int lat; logic [31:0] rd;
        do_txn(1, 1'b1, 7'h30, 32'hFFFF_FFFF, 4'hF, lat, rd);
        do_txn(1, 1'b1, 7'h30, 32'h0, 4'b0101, lat, rd);
        total++; if (snap_web !== (BYTE_WE ? 4'b1010 : 4'b0000)) begin
            bad++; $display("FAIL be_web: got %b want %b", snap_web, (BYTE_WE ? 4'b1010 : 4'b0000)); end
        do_txn(1, 1'b0, 7'h30, 32'h0, 4'h0, lat, rd);
        total++; if (rd !== (BYTE_WE ? 32'hFF00_FF00 : 32'h0)) begin
            bad++; $display("FAIL be_read: got %h want %h", rd, (BYTE_WE ? 32'hFF00_FF00 : 32'h0)); end
        do_txn(2, 1'b1, 7'h30, 32'h1234_5678, 4'b0000, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL be_zero_ack: got %0d want 3", lat); end
        do_txn(1, 1'b0, 7'h30, 32'h0, 4'h0, lat, rd);
        total++; if (rd !== (BYTE_WE ? 32'hFF00_FF00 : 32'h1234_5678)) begin
            bad++; $display("FAIL be_zero_read: got %h want %h", rd, (BYTE_WE ? 32'hFF00_FF00 : 32'h1234_5678)); end
    endtask

    task automatic test_write_isolation();
        int lat; logic [31:0] rd;
        do_txn(1, 1'b1, 7'h40, 32'hDEAD_BEEF, 4'hF, lat, rd);
        do_txn(2, 1'b0, 7'h40, 32'h0, 4'hF, lat, rd);
        total++; if (RDATA2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL iso_setup: got %h want deadbeef", RDATA2); end
        do_txn(2, 1'b1, 7'h44, $urandom, 4'hF, lat, rd);
        total++; if ({lat, RDATA2} !== {32'd3, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL iso_hold: got %0d/%h want 3/deadbeef", lat, RDATA2); end
    endtask

    task automatic test_random();
        int lat, r; logic [31:0] rd;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(1, 2);
            do_txn(r, 1'($urandom_range(0, 1)), 7'($urandom), $urandom, 4'($urandom), lat, rd);
            total++; if (lat !== 3) begin bad++; $display("FAIL rnd_lat%0d: got %0d want 3", i, lat); end
            total++; if ({RDATA1, RDATA2} !== {exp_rd[1], exp_rd[2]}) begin
                bad++; $display("FAIL rnd_data%0d: got %h want %h", i, {RDATA1, RDATA2}, {exp_rd[1], exp_rd[2]}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_byte_enables();
        test_write_isolation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
